// File: rtl/lcd_bus_arbiter.sv
// 8080-style LCD write-bus arbiter: panel reset sequencing plus round-robin sharing between a CPU port and a pixel stream.
// Optional pixel counter ports (pix_cnt_clr, pix_count) are built when LCD_ARB_PIXCNT_EN is defined.
module lcd_bus_arbiter #(
    parameter int WR_LOW       = 2,
    parameter int WR_HIGH      = 2,
    parameter int RST_LOW_CYC  = 500,
    parameter int RST_WAIT_CYC = 6000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_rst_req,
    input  logic        cpu_req,
    input  logic        cpu_dc,
    input  logic [15:0] cpu_data,
    output logic        cpu_ack,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic [15:0] lcd_data,
    output logic        lcd_dc,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic        lcd_reset_n,
    output logic        busy
`ifdef LCD_ARB_PIXCNT_EN
    ,
    input  logic        pix_cnt_clr,
    output logic [31:0] pix_count
`endif
);

    typedef enum logic [2:0] {RST_LO, RST_WAIT, IDLE, WR_LO, WR_HI} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        last_pix_q, last_pix_d;
    logic        rst_pend_q, rst_pend_d;
    logic [15:0] lcd_data_q, lcd_data_d;
    logic        lcd_dc_q, lcd_dc_d;
    logic        lcd_wr_q, lcd_wr_d;
    logic        lcd_reset_n_q, lcd_reset_n_d;
    logic        busy_q, busy_d;
    logic        grant_cpu, grant_pix;

    // A reset request in IDLE suppresses any grant in the same cycle.
    always_comb begin
        grant_cpu = 1'b0;
        grant_pix = 1'b0;
        if (state_q == IDLE && !lcd_rst_req) begin
            if (cpu_req && (!pix_valid || last_pix_q)) begin
                grant_cpu = 1'b1;
            end else if (pix_valid) begin
                grant_pix = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_pix_d = last_pix_q;
        rst_pend_d = rst_pend_q;
        lcd_data_d = lcd_data_q;
        lcd_dc_d   = lcd_dc_q;
        case (state_q)
            RST_LO: begin
                if (lcd_rst_req) begin
                    cnt_d = 32'd0;
                end else if (cnt_q == 32'(RST_LOW_CYC - 1)) begin
                    state_d = RST_WAIT;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RST_WAIT: begin
                if (lcd_rst_req) begin
                    state_d = RST_LO;
                    cnt_d   = 32'd0;
                end else if (cnt_q == 32'(RST_WAIT_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            IDLE: begin
                cnt_d = 32'd0;
                if (lcd_rst_req) begin
                    state_d = RST_LO;
                end else if (grant_cpu) begin
                    state_d    = WR_LO;
                    lcd_data_d = cpu_data;
                    lcd_dc_d   = cpu_dc;
                    last_pix_d = 1'b0;
                end else if (grant_pix) begin
                    state_d    = WR_LO;
                    lcd_data_d = pix_data;
                    lcd_dc_d   = 1'b1;
                    last_pix_d = 1'b1;
                end
            end
            WR_LO: begin
                if (lcd_rst_req) rst_pend_d = 1'b1;
                if (cnt_q == 32'(WR_LOW - 1)) begin
                    state_d = WR_HI;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WR_HI: begin
                if (lcd_rst_req) rst_pend_d = 1'b1;
                if (cnt_q == 32'(WR_HIGH - 1)) begin
                    // The write always finishes; a deferred reset request is honoured here.
                    state_d    = (rst_pend_q || lcd_rst_req) ? RST_LO : IDLE;
                    rst_pend_d = 1'b0;
                    cnt_d      = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = RST_LO;
                cnt_d   = 32'd0;
            end
        endcase
        lcd_wr_d      = (state_d != WR_LO);
        lcd_reset_n_d = (state_d != RST_LO);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RST_LO;
            cnt_q         <= 32'd0;
            last_pix_q    <= 1'b1;
            rst_pend_q    <= 1'b0;
            lcd_data_q    <= 16'h0000;
            lcd_dc_q      <= 1'b0;
            lcd_wr_q      <= 1'b1;
            lcd_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_pix_q    <= last_pix_d;
            rst_pend_q    <= rst_pend_d;
            lcd_data_q    <= lcd_data_d;
            lcd_dc_q      <= lcd_dc_d;
            lcd_wr_q      <= lcd_wr_d;
            lcd_reset_n_q <= lcd_reset_n_d;
            busy_q        <= busy_d;
        end
    end

    assign cpu_ack     = grant_cpu;
    assign pix_ready   = grant_pix;
    assign lcd_data    = lcd_data_q;
    assign lcd_dc      = lcd_dc_q;
    assign lcd_wr      = lcd_wr_q;
    assign lcd_rd      = 1'b1;
    assign lcd_reset_n = lcd_reset_n_q;
    assign busy        = busy_q;

`ifdef LCD_ARB_PIXCNT_EN
    logic [31:0] pix_cnt_q, pix_cnt_d;

    // Clear wins over a coincident accept; the counter wraps naturally.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (pix_cnt_clr) begin
            pix_cnt_d = 32'd0;
        end else if (grant_pix) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q <= 32'd0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign pix_count = pix_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with WR_LOW=2, WR_HIGH=1, RST_LOW_CYC=4, RST_WAIT_CYC=8.
module tb_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset, lcd_rst_req, cpu_req, cpu_dc, pix_valid;
    logic [15:0] cpu_data, pix_data;
    logic        cpu_ack, pix_ready, lcd_dc, lcd_wr, lcd_rd, lcd_reset_n, busy;
    logic [15:0] lcd_data;
`ifdef LCD_ARB_PIXCNT_EN
    logic        pix_cnt_clr;
    logic [31:0] pix_count;
`endif

    int total = 0;
    int bad   = 0;

    lcd_bus_arbiter #(
        .WR_LOW(2), .WR_HIGH(1), .RST_LOW_CYC(4), .RST_WAIT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset), .lcd_rst_req(lcd_rst_req),
        .cpu_req(cpu_req), .cpu_dc(cpu_dc), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .lcd_data(lcd_data), .lcd_dc(lcd_dc), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd),
        .lcd_reset_n(lcd_reset_n), .busy(busy)
`ifdef LCD_ARB_PIXCNT_EN
        , .pix_cnt_clr(pix_cnt_clr), .pix_count(pix_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b want 0 within 100 cycles", busy);
        end
    endtask

    task automatic test_reset();
        cpu_req = 0; pix_valid = 0; lcd_rst_req = 0; reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({lcd_data, lcd_dc, lcd_wr, lcd_rd, lcd_reset_n, busy, cpu_ack, pix_ready} !==
            {16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: data=%h dc=%b wr=%b rd=%b rst_n=%b busy=%b ack=%b rdy=%b want 0000 0 1 1 0 1 0 0",
                     lcd_data, lcd_dc, lcd_wr, lcd_rd, lcd_reset_n, busy, cpu_ack, pix_ready);
        end
        reset = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            total++;
            if (lcd_reset_n !== (k >= 4)) begin
                bad++;
                $display("FAIL reset_seq_rstn: cycle %0d lcd_reset_n=%b want %b", k, lcd_reset_n, (k >= 4));
            end
            total++;
            if (busy !== (k < 12)) begin
                bad++;
                $display("FAIL reset_seq_busy: cycle %0d busy=%b want %b", k, busy, (k < 12));
            end
            total++;
            if (lcd_wr !== 1'b1) begin
                bad++;
                $display("FAIL reset_seq_wr: cycle %0d lcd_wr=%b want 1", k, lcd_wr);
            end
        end
    endtask

    task automatic test_cpu_write();
        wait_idle();
        cpu_req = 1; cpu_dc = 0; cpu_data = 16'h002C;
        #1;
        total++;
        if (cpu_ack !== 1'b1 || pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL cpu_accept: ack=%b rdy=%b want 1 0", cpu_ack, pix_ready);
        end
        @(posedge clk); #1;
        cpu_req = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (lcd_wr !== (k >= 3) || busy !== (k < 4) || cpu_ack !== 1'b0 ||
                lcd_data !== 16'h002C || lcd_dc !== 1'b0) begin
                bad++;
                $display("FAIL cpu_write: cycle %0d wr=%b busy=%b ack=%b data=%h dc=%b want wr=%b busy=%b ack=0 data=002c dc=0",
                         k, lcd_wr, busy, cpu_ack, lcd_data, lcd_dc, (k >= 3), (k < 4));
            end
        end
    endtask

    task automatic test_round_robin();
        int ng;
        logic chk, upd_pix, exp_cpu;
        logic [16:0] exp_w;
        ng = 0; chk = 0; upd_pix = 0; exp_w = '0;
        cpu_req = 1; cpu_dc = 0; cpu_data = 16'h00AA;
        pix_valid = 1; pix_data = 16'hF800; reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        for (int t = 1; t <= 40 && ng < 4; t++) begin
            @(negedge clk);
            if (chk) begin
                total++;
                if ({lcd_dc, lcd_data} !== exp_w) begin
                    bad++;
                    $display("FAIL rr_data: dc/data=%h want %h", {lcd_dc, lcd_data}, exp_w);
                end
                chk = 0;
            end
            total++;
            if (cpu_ack === 1'b1 && pix_ready === 1'b1) begin
                bad++;
                $display("FAIL rr_both: cycle %0d ack=1 rdy=1 want at most one", t);
            end
            if (cpu_ack === 1'b1 || pix_ready === 1'b1) begin
                exp_cpu = (ng % 2 == 0);
                total++;
                if (cpu_ack !== exp_cpu) begin
                    bad++;
                    $display("FAIL rr_order: grant %0d cpu_ack=%b want %b", ng, cpu_ack, exp_cpu);
                end
                total++;
                if (t != 12 + 4 * ng) begin
                    bad++;
                    $display("FAIL rr_timing: grant %0d at cycle %0d want %0d", ng, t, 12 + 4 * ng);
                end
                exp_w = cpu_ack ? {1'b0, 16'h00AA} : {1'b1, pix_data};
                chk = 1;
                upd_pix = pix_ready;
                ng++;
            end
            @(posedge clk); #1;
            if (upd_pix) begin
                pix_data = 16'h07E0;
                upd_pix = 0;
            end
            if (ng == 4) begin
                cpu_req = 0;
                pix_valid = 0;
            end
        end
        if (chk) begin
            @(negedge clk);
            total++;
            if ({lcd_dc, lcd_data} !== exp_w) begin
                bad++;
                $display("FAIL rr_data_last: dc/data=%h want %h", {lcd_dc, lcd_data}, exp_w);
            end
        end
        total++;
        if (ng != 4) begin
            bad++;
            $display("FAIL rr_count: grants=%0d want 4", ng);
        end
    endtask

    task automatic test_pix_stream();
        int n, prev;
        logic chk, upd;
        logic [15:0] exp_d;
        wait_idle();
`ifdef LCD_ARB_PIXCNT_EN
        pix_cnt_clr = 1;
        @(posedge clk); #1;
        pix_cnt_clr = 0;
`endif
        n = 0; prev = 0; chk = 0; upd = 0; exp_d = '0;
        pix_valid = 1; pix_data = 16'h1000;
        #1;
        for (int t = 0; t < 80 && n < 10; t++) begin
            if (chk) begin
                total++;
                if (lcd_dc !== 1'b1 || lcd_data !== exp_d) begin
                    bad++;
                    $display("FAIL pix_data: dc=%b data=%h want 1 %h", lcd_dc, lcd_data, exp_d);
                end
                chk = 0;
            end
            if (pix_ready === 1'b1) begin
                if (n > 0) begin
                    total++;
                    if (t - prev != 4) begin
                        bad++;
                        $display("FAIL pix_spacing: word %0d gap=%0d want 4", n, t - prev);
                    end
                end
                prev = t;
                exp_d = pix_data;
                chk = 1;
                n++;
                upd = 1;
            end
            @(posedge clk); #1;
            if (upd) begin
                pix_data = 16'h1000 + 16'(n);
                if (n == 10) pix_valid = 0;
                upd = 0;
            end
            @(negedge clk);
        end
        if (chk) begin
            total++;
            if (lcd_dc !== 1'b1 || lcd_data !== exp_d) begin
                bad++;
                $display("FAIL pix_data_last: dc=%b data=%h want 1 %h", lcd_dc, lcd_data, exp_d);
            end
        end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL pix_count_pulses: got %0d want 10", n);
        end
`ifdef LCD_ARB_PIXCNT_EN
        total++;
        if (pix_count !== 32'd10) begin
            bad++;
            $display("FAIL pix_count_10: got %0d want 10", pix_count);
        end
`endif
    endtask

    task automatic test_rst_idle();
        wait_idle();
        cpu_req = 1; cpu_dc = 0; cpu_data = 16'h0001; lcd_rst_req = 1;
        #1;
        total++;
        if (cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle_ack: ack=%b want 0", cpu_ack);
        end
        @(posedge clk); #1;
        lcd_rst_req = 0;
        total++;
        if (lcd_reset_n !== 1'b0 || busy !== 1'b1 || cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle_seq: rst_n=%b busy=%b ack=%b want 0 1 0", lcd_reset_n, busy, cpu_ack);
        end
        cpu_req = 0;
    endtask

    task automatic test_rst_during_write();
        wait_idle();
        cpu_req = 1; cpu_dc = 1; cpu_data = 16'h1234;
        #1;
        total++;
        if (cpu_ack !== 1'b1) begin
            bad++;
            $display("FAIL rstw_accept: ack=%b want 1", cpu_ack);
        end
        @(posedge clk); #1;
        cpu_req = 0;
        @(posedge clk); #1;
        lcd_rst_req = 1;
        total++;
        if (lcd_wr !== 1'b0) begin
            bad++;
            $display("FAIL rstw_wrlo: lcd_wr=%b want 0", lcd_wr);
        end
        @(posedge clk); #1;
        lcd_rst_req = 0; cpu_req = 1; cpu_dc = 0; pix_valid = 1;
        total++;
        if (lcd_wr !== 1'b1 || lcd_reset_n !== 1'b1 || lcd_data !== 16'h1234 || lcd_dc !== 1'b1 ||
            cpu_ack !== 1'b0 || pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstw_wrhi: wr=%b rst_n=%b data=%h dc=%b ack=%b rdy=%b want 1 1 1234 1 0 0",
                     lcd_wr, lcd_reset_n, lcd_data, lcd_dc, cpu_ack, pix_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (lcd_reset_n !== (k == 5) || lcd_wr !== 1'b1 || cpu_ack !== 1'b0 || pix_ready !== 1'b0) begin
                bad++;
                $display("FAIL rstw_seq: cycle %0d rst_n=%b wr=%b ack=%b rdy=%b want %b 1 0 0",
                         k, lcd_reset_n, lcd_wr, cpu_ack, pix_ready, (k == 5));
            end
        end
        cpu_req = 0; pix_valid = 0;
    endtask

    task automatic test_abort();
        wait_idle();
        cpu_req = 1; cpu_dc = 0; cpu_data = 16'h5555;
        @(posedge clk); #1;
        cpu_req = 0;
        total++;
        if (lcd_wr !== 1'b0) begin
            bad++;
            $display("FAIL abort_wrlo: lcd_wr=%b want 0", lcd_wr);
        end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        total++;
        if (lcd_wr !== 1'b1 || lcd_reset_n !== 1'b0 || busy !== 1'b1 || lcd_data !== 16'h0000) begin
            bad++;
            $display("FAIL abort_reset: wr=%b rst_n=%b busy=%b data=%h want 1 0 1 0000",
                     lcd_wr, lcd_reset_n, busy, lcd_data);
        end
    endtask

`ifdef LCD_ARB_PIXCNT_EN
    task automatic test_pixcnt();
        wait_idle();
        force dut.pix_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.pix_cnt_q;
        total++;
        if (pix_count !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL pixcnt_preload: got %h want ffffffff", pix_count);
        end
        pix_valid = 1; pix_data = 16'hABCD;
        @(posedge clk); #1;
        pix_valid = 0;
        total++;
        if (pix_count !== 32'd0) begin
            bad++;
            $display("FAIL pixcnt_wrap: got %h want 0", pix_count);
        end
        wait_idle();
        pix_valid = 1;
        @(posedge clk); #1;
        pix_valid = 0;
        total++;
        if (pix_count !== 32'd1) begin
            bad++;
            $display("FAIL pixcnt_inc: got %0d want 1", pix_count);
        end
        wait_idle();
        pix_valid = 1; pix_cnt_clr = 1;
        #1;
        total++;
        if (pix_ready !== 1'b1) begin
            bad++;
            $display("FAIL pixcnt_clr_ready: rdy=%b want 1", pix_ready);
        end
        @(posedge clk); #1;
        pix_valid = 0; pix_cnt_clr = 0;
        total++;
        if (pix_count !== 32'd0) begin
            bad++;
            $display("FAIL pixcnt_clr_wins: got %0d want 0", pix_count);
        end
    endtask
`endif

    initial begin
        reset = 1; lcd_rst_req = 0; cpu_req = 0; cpu_dc = 0; cpu_data = '0;
        pix_valid = 0; pix_data = '0;
`ifdef LCD_ARB_PIXCNT_EN
        pix_cnt_clr = 0;
`endif
        test_reset();
        test_cpu_write();
        test_round_robin();
        test_pix_stream();
        test_rst_idle();
        test_rst_during_write();
        test_abort();
`ifdef LCD_ARB_PIXCNT_EN
        test_pixcnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
